// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back arbiter.
package wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREG   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO buffering long-latency write-back requests.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t wdata,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    wb_req_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the register-file write port between the primary result path and
// a FIFO of long-latency results, with a pending-destination scoreboard.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_valid,
    input  logic [4:0]        p_rd,
    input  logic [XLEN-1:0]   p_data,
    output logic              prim_stall,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [4:0]        s_rd,
    input  logic [XLEN-1:0]   s_data,
    input  logic              iss_valid,
    input  logic [4:0]        iss_rd,
    input  logic [4:0]        chk_rs1,
    input  logic [4:0]        chk_rs2,
    input  logic [4:0]        chk_rd,
    output logic              hazard,
    output logic [NREG-1:0]   busy,
    output logic              rf_wr,
    output logic [4:0]        rf_rd,
    output logic [XLEN-1:0]   rf_data
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic            full, empty, push, pop, force_pop;
    wb_req_t         head, s_req;
    logic [CW-1:0]   wait_q, wait_d;
    logic [NREG-1:0] busy_q, busy_d;

    assign s_ready = !full;
    assign push    = s_valid && !full;
    assign s_req   = '{rd: s_rd, data: s_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (s_req),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign force_pop = !empty && (wait_q >= CW'(MAX_WAIT));

    // rf_wr is held low while in reset so a held primary request is not written.
    always_comb begin
        pop        = 1'b0;
        rf_wr      = 1'b0;
        rf_rd      = '0;
        rf_data    = '0;
        prim_stall = p_valid && force_pop;
        if (p_valid && !force_pop) begin
            rf_wr   = rst_n && (p_rd != '0);
            rf_rd   = p_rd;
            rf_data = p_data;
        end else if (!empty) begin
            pop     = 1'b1;
            rf_wr   = rst_n && (head.rd != '0);
            rf_rd   = head.rd;
            rf_data = head.data;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (empty || pop) begin
            wait_d = '0;
        end else if (wait_q < CW'(MAX_WAIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // A new issue to the same register outranks the retiring write.
    always_comb begin
        busy_d = busy_q;
        if (pop && head.rd != '0) busy_d[head.rd] = 1'b0;
        if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            busy_q <= '0;
        end else begin
            wait_q <= wait_d;
            busy_q <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];

endmodule
